// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch-queue to ID-stage valid/ready handshake
interface if_fetch_queue_if;
  logic [31:0] inst_id;
  logic [29:0] pc_id;
  logic        inst_valid_id;
  logic        id_ready;

  modport master (output inst_id, output pc_id, output inst_valid_id, input id_ready);
  modport slave  (input inst_id, input pc_id, input inst_valid_id, output id_ready);
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage with QDEPTH-entry queue toward ID
// Optional IF_PERF_CNT_EN adds dequeue and bubble counters.
module if_fetch_queue #(
  parameter int          IWIDTH   = 12,
  parameter int          QDEPTH   = 4,
  parameter logic [29:0] RESET_PC = 30'd0,
  localparam int         PW       = $clog2(QDEPTH),
  localparam int         CW       = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_start,
  input  logic [29:0]       start_adr,
  input  logic              jmp_condition_ex,
  input  logic [29:0]       jmp_adr_ex,
  input  logic              ecall_condition_ex,
  input  logic              g_interrupt,
  input  logic              g_exception,
  input  logic [29:0]       csr_mtvec_ex,
  input  logic              cmd_mret_ex,
  input  logic              cmd_sret_ex,
  input  logic              cmd_uret_ex,
  input  logic [29:0]       csr_mepc_ex,
  input  logic [29:0]       csr_sepc_ex,
  if_fetch_queue_if.master  id_if,
  output logic              post_jump_cmd_cond,
  input  logic              i_read_sel,
  input  logic [IWIDTH-1:0] i_ram_radr,
  output logic [31:0]       i_ram_rdata,
  input  logic [IWIDTH-1:0] i_ram_wadr,
  input  logic [31:0]       i_ram_wdata,
  input  logic              i_ram_wen,
  output logic [CW-1:0]     q_count,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt,
`endif
  output logic [31:0]       pc_data
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] iram [2**IWIDTH];
  logic [31:0] qinst [QDEPTH];
  logic [29:0] qpc [QDEPTH];

  logic [29:0]       pc_q, pc_d, inflight_pc_q, inflight_pc_d, redir_tgt;
  logic              inflight_q, inflight_d;
  logic              post_trap_q, post_trap_d, post_jump_q, post_jump_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       ram_rdata_q, ram_rdata_d;
  logic [IWIDTH-1:0] ram_radr;
  logic              trap, jc, redir, flush, issue, deq, enq, q_empty;

  always_comb begin
    trap  = ecall_condition_ex | g_interrupt | g_exception;
    jc    = jmp_condition_ex | cmd_mret_ex | cmd_sret_ex | cmd_uret_ex;
    // an xRET/jump right behind a trap belongs to the trapped stream
    redir = trap | (jc & ~post_trap_q);
    if (trap)             redir_tgt = csr_mtvec_ex;
    else if (cmd_mret_ex) redir_tgt = csr_mepc_ex;
    else if (cmd_sret_ex) redir_tgt = csr_sepc_ex;
    else                  redir_tgt = jmp_adr_ex;

    flush   = pc_start | redir;
    q_empty = (count_q == '0);
    issue   = ~i_read_sel & ~flush & ((int'(count_q) + int'(inflight_q)) < QDEPTH);
    deq     = ~q_empty & id_if.id_ready;
    enq     = inflight_q & ~flush;

    ram_radr    = i_read_sel ? i_ram_radr : pc_q[IWIDTH-1:0];
    ram_rdata_d = iram[ram_radr];

    pc_d = pc_q;
    if (pc_start)   pc_d = start_adr;
    else if (redir) pc_d = redir_tgt;
    else if (issue) pc_d = pc_q + 30'd1;

    inflight_d    = issue;
    inflight_pc_d = pc_q;
    post_trap_d   = trap;
    post_jump_d   = jc;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      post_trap_q   <= 1'b0;
      post_jump_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ram_rdata_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      post_trap_q   <= post_trap_d;
      post_jump_q   <= post_jump_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ram_rdata_q   <= ram_rdata_d;
    end
  end

  // storage arrays carry no reset; empty-queue outputs are forced below
  always_ff @(posedge clk) begin
    if (i_ram_wen) iram[i_ram_wadr] <= i_ram_wdata;
    if (enq) begin
      qinst[wr_ptr_q] <= ram_rdata_q;
      qpc[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign id_if.inst_valid_id = ~q_empty;
  assign id_if.inst_id       = q_empty ? NOP : qinst[rd_ptr_q];
  assign id_if.pc_id         = q_empty ? 30'd0 : qpc[rd_ptr_q];
  assign post_jump_cmd_cond  = post_jump_q;
  assign i_ram_rdata         = ram_rdata_q;
  assign q_count             = count_q;
  assign pc_data             = {pc_q, 2'b00};

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d, perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q + 32'(deq);
    perf_bubble_d = perf_bubble_q + 32'(id_if.id_ready & q_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;
  localparam int IWIDTH = 12;
  localparam int QDEPTH = 4;
  localparam int CW     = $clog2(QDEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              pc_start = 0, jmp_condition_ex = 0, ecall_condition_ex = 0;
  logic              g_interrupt = 0, g_exception = 0;
  logic              cmd_mret_ex = 0, cmd_sret_ex = 0, cmd_uret_ex = 0;
  logic [29:0]       start_adr = 0, jmp_adr_ex = 0, csr_mtvec_ex = 0, csr_mepc_ex = 0, csr_sepc_ex = 0;
  logic              post_jump_cmd_cond;
  logic              i_read_sel = 1'b1;
  logic [IWIDTH-1:0] i_ram_radr = 0, i_ram_wadr = 0;
  logic [31:0]       i_ram_rdata, i_ram_wdata = 0;
  logic              i_ram_wen = 0;
  logic [CW-1:0]     q_count;
  logic [31:0]       pc_data;

  if_fetch_queue_if id_bus ();

  if_fetch_queue #(.IWIDTH(IWIDTH), .QDEPTH(QDEPTH), .RESET_PC(30'd0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_start(pc_start), .start_adr(start_adr),
    .jmp_condition_ex(jmp_condition_ex), .jmp_adr_ex(jmp_adr_ex),
    .ecall_condition_ex(ecall_condition_ex), .g_interrupt(g_interrupt),
    .g_exception(g_exception), .csr_mtvec_ex(csr_mtvec_ex),
    .cmd_mret_ex(cmd_mret_ex), .cmd_sret_ex(cmd_sret_ex), .cmd_uret_ex(cmd_uret_ex),
    .csr_mepc_ex(csr_mepc_ex), .csr_sepc_ex(csr_sepc_ex), .id_if(id_bus.master),
    .post_jump_cmd_cond(post_jump_cmd_cond), .i_read_sel(i_read_sel),
    .i_ram_radr(i_ram_radr), .i_ram_rdata(i_ram_rdata), .i_ram_wadr(i_ram_wadr),
    .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen), .q_count(q_count),
    .pc_data(pc_data)
  );

  int total = 0, bad = 0, n_deq = 0;
  logic [31:0] mmem [2**IWIDTH];
  logic [29:0] exp_q [$];
  logic [29:0] exp_tail, mon_pc;
  logic cyc_flush = 0, mon_en = 0, exp_post_jump = 0, m_post_trap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected ID stream after a redirect to a: a, a+1, a+2, ... (mod 2^30)
  task automatic restart_stream(input logic [29:0] a);
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(a + 30'(k));
    exp_tail = a + 30'd15;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("post_jump", post_jump_cmd_cond, exp_post_jump);
      if (!id_bus.inst_valid_id) begin
        chk("empty_inst", id_bus.inst_id, 32'h13);
        chk("empty_pc", id_bus.pc_id, 30'd0);
      end else if (id_bus.id_ready && !cyc_flush) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          mon_pc = exp_q.pop_front();
          chk("sb_pc", id_bus.pc_id, mon_pc);
          chk("sb_inst", id_bus.inst_id, mmem[mon_pc[IWIDTH-1:0]]);
          n_deq++;
          exp_tail = exp_tail + 30'd1;
          exp_q.push_back(exp_tail);
        end
      end
    end
  end

  // Applies the current inputs for one cycle; model decides redirect from the rules.
  task automatic cycle();
    logic trap, jc, redir, psel;
    logic [29:0] tgt;
    logic [IWIDTH-1:0] padr;
    trap  = ecall_condition_ex | g_interrupt | g_exception;
    jc    = jmp_condition_ex | cmd_mret_ex | cmd_sret_ex | cmd_uret_ex;
    redir = trap | (jc & ~m_post_trap);
    tgt   = trap ? csr_mtvec_ex : cmd_mret_ex ? csr_mepc_ex : cmd_sret_ex ? csr_sepc_ex : jmp_adr_ex;
    cyc_flush = pc_start | redir;
    if (pc_start) restart_stream(start_adr);
    else if (redir) restart_stream(tgt);
    psel = i_read_sel;
    padr = i_ram_radr;
    @(posedge clk);
    #1;
    m_post_trap   = trap;
    exp_post_jump = jc;
    if (psel) chk("mon_rdata", i_ram_rdata, mmem[padr]);
  endtask

  task automatic clear_inputs();
    pc_start = 0; jmp_condition_ex = 0; ecall_condition_ex = 0;
    g_interrupt = 0; g_exception = 0;
    cmd_mret_ex = 0; cmd_sret_ex = 0; cmd_uret_ex = 0;
    i_read_sel = 0; i_ram_wen = 0;
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst_n  = 0;
    clear_inputs();
    id_bus.id_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", id_bus.inst_valid_id, 0);
    chk("rst_inst", id_bus.inst_id, 32'h13);
    chk("rst_pc_id", id_bus.pc_id, 0);
    chk("rst_count", q_count, 0);
    chk("rst_post", post_jump_cmd_cond, 0);
    chk("rst_pc_data", pc_data, 0);
    m_post_trap = 0; exp_post_jump = 0; cyc_flush = 0;
    restart_stream(30'd0);
    rst_n  = 1;
    mon_en = 1;
  endtask

  initial begin
    id_bus.id_ready = 1'b0;
    // load IRAM while reset holds the stage idle
    i_read_sel = 1;
    for (int a = 0; a < 2**IWIDTH; a++) begin
      i_ram_wadr  = IWIDTH'(a);
      i_ram_wdata = $urandom;
      mmem[a]     = i_ram_wdata;
      i_ram_wen   = 1;
      @(posedge clk); #1;
    end
    i_ram_wen = 0;

    // 1: first fetch visible in cycle 2, then no bubbles
    do_reset();
    chk("t1_c0_valid", id_bus.inst_valid_id, 0);
    cycle();
    chk("t1_c1_valid", id_bus.inst_valid_id, 0);
    cycle();
    chk("t1_c2_valid", id_bus.inst_valid_id, 1);
    chk("t1_c2_pc", id_bus.pc_id, 0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t1_stream_valid", id_bus.inst_valid_id, 1);
    end

    // 2: back-pressure saturates the queue
    do_reset();
    id_bus.id_ready = 0;
    repeat (10) cycle();
    chk("t2_count_full", q_count, QDEPTH);
    chk("t2_pc_held", pc_data, {30'd4, 2'b00});
    chk("t2_head_pc", id_bus.pc_id, 0);
    id_bus.id_ready = 1;
    repeat (8) cycle();

    // 3: jump flushes a queue holding 3 entries
    do_reset();
    id_bus.id_ready = 0;
    repeat (4) cycle();
    chk("t3_count3", q_count, 3);
    jmp_condition_ex = 1; jmp_adr_ex = 30'h40; id_bus.id_ready = 1;
    cycle();
    jmp_condition_ex = 0;
    chk("t3_flush_valid", id_bus.inst_valid_id, 0);
    chk("t3_flush_count", q_count, 0);
    cycle();
    cycle();
    chk("t3_first_valid", id_bus.inst_valid_id, 1);
    chk("t3_first_pc", id_bus.pc_id, 30'h40);
    repeat (4) cycle();

    // 4: trap beats jump; following mret is ignored
    g_interrupt = 1; jmp_condition_ex = 1; csr_mtvec_ex = 30'h80; jmp_adr_ex = 30'h40;
    cycle();
    g_interrupt = 0; jmp_condition_ex = 0; cmd_mret_ex = 1; csr_mepc_ex = 30'h200;
    chk("t4_post1", post_jump_cmd_cond, 1);
    cycle();
    cmd_mret_ex = 0;
    chk("t4_post2", post_jump_cmd_cond, 1);
    chk("t4_pc_data", pc_data, {30'h81, 2'b00});
    cycle();
    chk("t4_first_valid", id_bus.inst_valid_id, 1);
    chk("t4_first_pc", id_bus.pc_id, 30'h80);
    repeat (4) cycle();

    // 5: monitor read stalls fetch
    do_reset();
    repeat (3) cycle();
    i_read_sel = 1; i_ram_radr = 5;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t5_pc_hold", pc_data, {30'd3, 2'b00});
    end
    i_read_sel = 0;
    repeat (8) cycle();

    // 6: pc_start wins over a simultaneous trap
    g_exception = 1; csr_mtvec_ex = 30'h80; pc_start = 1; start_adr = 30'h100;
    cycle();
    clear_inputs();
    chk("t6_pc", pc_data, {30'h100, 2'b00});
    chk("t6_valid", id_bus.inst_valid_id, 0);
    chk("t6_count", q_count, 0);
    cycle();
    cycle();
    chk("t6_first_pc", id_bus.pc_id, 30'h100);
    repeat (4) cycle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      clear_inputs();
      r = $urandom_range(0, 99);
      jmp_condition_ex   = (r < 4) || (r == 11);
      g_interrupt        = (r == 4) || (r == 11);
      g_exception        = (r == 5);
      ecall_condition_ex = (r == 6);
      cmd_mret_ex        = (r == 7);
      cmd_sret_ex        = (r == 8);
      cmd_uret_ex        = (r == 9);
      pc_start           = (r == 10);
      if (m_post_trap && $urandom_range(0, 1) == 1) cmd_mret_ex = 1;
      jmp_adr_ex   = 30'($urandom);
      csr_mtvec_ex = 30'($urandom);
      csr_mepc_ex  = 30'($urandom);
      csr_sepc_ex  = 30'($urandom);
      start_adr    = 30'($urandom);
      id_bus.id_ready = ($urandom_range(0, 3) != 0);
      i_read_sel   = ($urandom_range(0, 9) == 0);
      i_ram_radr   = IWIDTH'($urandom);
      cycle();
    end
    clear_inputs();
    repeat (4) cycle();
    mon_en = 0;
    chk("liveness", (n_deq > 500), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised successor to the single-register instruction fetch stage. It decouples instruction-RAM fetch from ID-stage back-pressure with a QDEPTH-entry instruction/PC queue and a valid/ready handshake to ID. Redirects from EX (jump/branch, trap, xRET) flush the queue and discard any read still in flight. The block sits between the PC/IRAM and the ID stage, and shares the IRAM read port with the monitor.

Parameters:
IWIDTH, 12, IRAM word-address width; the IRAM holds 2^IWIDTH 32-bit words.
QDEPTH, 4, number of queue entries; power of two, 2..16.
RESET_PC, 30'd0, value loaded into pc_if at reset, in word units ([31:2]).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc_start  in  1  load start_adr into the PC and flush the queue
start_adr  in  30  start address, [31:2]
jmp_condition_ex  in  1  branch/jump taken in EX
jmp_adr_ex  in  30  branch/jump target
ecall_condition_ex  in  1  ecall in EX
g_interrupt  in  1  interrupt taken
g_exception  in  1  exception taken
csr_mtvec_ex  in  30  trap vector
cmd_mret_ex / cmd_sret_ex / cmd_uret_ex  in  1 each  xRET in EX
csr_mepc_ex / csr_sepc_ex  in  30 each  return addresses
id_ready  in  1  ID accepts the head entry this cycle
inst_id  out  32  head instruction; 32'h0000_0013 when the queue is empty
pc_id  out  30  PC of the head entry; 0 when empty
inst_valid_id  out  1  the head entry is valid
post_jump_cmd_cond  out  1  jump-class command seen in EX last cycle (registered)
i_read_sel  in  1  monitor owns the IRAM read port
i_ram_radr  in  IWIDTH  monitor read address
i_ram_rdata  out  32  IRAM read data to the monitor
i_ram_wadr  in  IWIDTH  write address
i_ram_wdata  in  32  write data
i_ram_wen  in  1  write enable
q_count  out  log2(QDEPTH)+1  current occupancy
pc_data  out  32  {pc_if, 2'b00}

Behaviour:
- Reset: pc_if=RESET_PC; queue empty; inflight=0; inst_valid_id=0; inst_id=32'h13; pc_id=0; q_count=0; post flags=0.
- Trap condition: trap = ecall_condition_ex | g_interrupt | g_exception.
- Jump-class condition: jc = jmp_condition_ex | any xRET.
- Redirect: redir = trap | (jc & ~post_trap), where post_trap is trap registered one cycle.
- Redirect target: mtvec if trap, else mepc if mret, else sepc if sret, else jmp_adr_ex. uret with no other condition uses jmp_adr_ex.
- Priority: pc_start > redir > issue.
- On pc_start or redir:
  - pc_if takes the new address.
  - All queue entries and any in-flight read are invalidated in the same edge.
  - inst_valid_id=0 in the next cycle.
  - A simultaneous dequeue is ignored.
- Issue: issue = ~i_read_sel & ~redir & ~pc_start & (count + inflight < QDEPTH).
  - On issue: IRAM reads pc_if[IWIDTH+1:2] and pc_if increments by 1, wrapping at 2^30.
  - inflight = issue registered one cycle.
  - The returned data and PC are enqueued at the tail on the next edge.
- IRAM: synchronous read, 1-cycle latency. Read address = i_read_sel ? i_ram_radr : pc_if. i_ram_rdata is the raw RAM output.
- Dequeue: inst_valid_id & id_ready advances the head.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Full: issue is blocked by the count+inflight guard, so no overflow is possible.
  - Empty: inst_id=NOP and inst_valid_id=0.
- Pointers wrap modulo QDEPTH. Minimum fetch-to-ID latency is 2 cycles (issue, then the entry is visible).
- pc_start asserted together with redir: pc_start wins.
- Reset asserted mid-operation clears everything asynchronously.

Optional Feature:
IF_PERF_CNT_EN:
- When defined: adds two 32-bit outputs.
  - perf_fetch_cnt: increments on every dequeue.
  - perf_bubble_cnt: increments on every cycle with id_ready=1 and inst_valid_id=0.
  - Both counters reset to 0, wrap, and are not cleared by redirect.
- When undefined: the ports and logic are absent.

Test Plan:
1. Reset, then IRAM[0..7]=i0..i7 with id_ready=1 -> inst_valid_id rises in cycle 2; pc_id=0,1,2,... on consecutive cycles with no bubbles.
2. id_ready=0 for 10 cycles -> q_count saturates at QDEPTH (4); pc_if stops at 4; release -> i0..i3 in order, then i4.
3. jmp_condition_ex=1 with jmp_adr_ex=30'h40 while the queue holds 3 entries -> next cycle inst_valid_id=0 and q_count=0; first valid pc_id=30'h40 two cycles later.
4. g_interrupt and jmp_condition_ex in the same cycle (mtvec=30'h80), then cmd_mret_ex one cycle later -> target 30'h80; the mret is ignored; post_jump_cmd_cond=1 in both following cycles.
5. i_read_sel=1 for 3 cycles with i_ram_radr=5 -> i_ram_rdata=IRAM[5]; no issue occurs and pc_if holds; fetch resumes at the same PC afterwards.
6. pc_start with start_adr=30'h100 asserted together with a trap -> pc_if=30'h100; the queue is flushed.
